// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and slave state type shared between the master and the SRAM slave.
package ahb_pkg;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } slave_state_e;
endpackage

// File: rtl/ahb_sram_array.sv
// ahb_sram_array: word-wide storage with per-byte write enables and asynchronous read.
module ahb_sram_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];

    for (genvar b = 0; b < 4; b++) begin : g_lane
        always_ff @(posedge clk) begin
            if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
    end

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite SRAM slave with configurable wait states, byte-lane writes
// and the two-cycle ERROR response for misaligned, oversized or out-of-range accesses.
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    slave_state_e  r_state, w_next;
    logic [AW-1:0] r_idx;
    logic [3:0]    r_be, r_cnt, w_be, w_we;
    logic          r_write;
    logic [31:0]   r_hrdata, w_rdata;
    logic          w_accept, w_legal, w_misalign, w_rd_data;
    logic          w_unused;

    assign w_unused   = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};
    assign w_misalign = (HSIZE == SIZE_HALF && HADDR[0]) || (HSIZE == SIZE_WORD && HADDR[1:0] != 2'b00);
    assign w_legal    = HSIZE <= SIZE_WORD && !w_misalign && ({2'b00, HADDR[31:2]} < 32'(MEM_DEPTH));
    assign w_accept   = HSEL && HREADY && HTRANS[1] && HREADYOUT;
    assign w_be       = HSIZE == SIZE_WORD ? 4'hF :
                        HSIZE == SIZE_HALF ? (HADDR[1] ? 4'hC : 4'h3) :
                        4'(4'b0001 << HADDR[1:0]);
    assign w_rd_data  = r_state == S_DATA && !r_write;
    assign w_we       = (r_state == S_DATA && r_write) ? r_be : 4'h0;

    always_comb begin
        w_next    = r_state;
        HREADYOUT = !(r_state == S_WAIT || r_state == S_ERR1);
        HRESP     = (r_state == S_ERR1 || r_state == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
        HRDATA    = w_rd_data ? w_rdata : r_hrdata;
        w_next    = r_state == S_WAIT ? (r_cnt == 4'd0 ? S_DATA : S_WAIT) :
                    r_state == S_ERR1 ? S_ERR2 :
                    !w_accept         ? S_IDLE :
                    !w_legal          ? S_ERR1 :
                    WAIT_STATES > 0   ? S_WAIT : S_DATA;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_be     <= 4'h0;
            r_write  <= 1'b0;
            r_cnt    <= 4'h0;
            r_hrdata <= 32'h0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= r_state == S_WAIT ? r_cnt - 4'd1 : WS_LOAD;
            r_hrdata <= w_rd_data ? w_rdata : r_hrdata;
            if (w_accept) begin
                r_idx   <= HADDR[AW+1:2];
                r_be    <= w_be;
                r_write <= HWRITE;
            end
        end
    end

    ahb_sram_array #(.DEPTH(MEM_DEPTH), .AW(AW)) u_array (
        .clk     (HCLK),
        .i_we    (w_we),
        .i_addr  (r_idx),
        .i_wdata (HWDATA),
        .o_rdata (w_rdata)
    );
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: directed bench driving a zero-wait and a three-wait-state slave
// on a shared bus; each cycle drives one address phase plus the previous transfer's write data.
module tb_ahb_lite_sram_slave;
    localparam logic [1:0] TI = 2'b00, TN = 2'b10;
    localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

    logic        hclk = 1'b0, hresetn = 1'b0;
    logic        hsel0 = 1'b0, hsel3 = 1'b0, hwrite = 1'b0, use3 = 1'b0;
    logic [31:0] haddr = 32'h0, hwdata = 32'h0;
    logic [2:0]  hsize = 3'd0;
    logic [1:0]  htrans = 2'b00;
    logic        hready;
    logic [31:0] rdata0, rdata3;
    logic        ro0, ro3, resp0, resp3;
    int          n_checks = 0, n_fail = 0;

    always #5 hclk = ~hclk;
    assign hready = use3 ? ro3 : ro0;

    ahb_lite_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd0), .HTRANS(htrans), .HMASTLOCK(1'b0),
        .HREADY(hready), .HWDATA(hwdata), .HRDATA(rdata0), .HREADYOUT(ro0), .HRESP(resp0)
    );

    ahb_lite_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(3)) dut3 (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel3), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd0), .HTRANS(htrans), .HMASTLOCK(1'b0),
        .HREADY(hready), .HWDATA(hwdata), .HRDATA(rdata3), .HREADYOUT(ro3), .HRESP(resp3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] tr, input logic [31:0] a, input logic w,
                       input logic [2:0] sz, input logic [31:0] wd);
        @(posedge hclk);
        #1;
        hsel0  = tr[1] && !use3;
        hsel3  = tr[1] && use3;
        htrans = tr;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        hwdata = wd;
        @(negedge hclk);
    endtask

    task automatic wr3(input logic [31:0] a, input logic [31:0] d);
        cyc(TN, a, 1'b1, SW, 32'h0);
        for (int i = 0; i < 4; i++) cyc(TI, 32'h0, 1'b0, SB, i == 3 ? d : 32'h0BAD0BAD);
    endtask

    initial begin
        repeat (2) @(posedge hclk);
        #1 hresetn = 1'b1;
        @(negedge hclk);
        check("rst_ready0", 32'(ro0), 32'd1);
        check("rst_resp0", 32'(resp0), 32'd0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_ready3", 32'(ro3), 32'd1);

        // word write then read-after-write
        cyc(TN, 32'h10, 1'b1, SW, 32'h0);
        cyc(TN, 32'h10, 1'b0, SW, 32'hDEADBEEF);
        check("raw_wr_ready", 32'(ro0), 32'd1);
        check("raw_wr_resp", 32'(resp0), 32'd0);
        cyc(TI, 32'h0, 1'b0, SB, 32'h0);
        check("raw_rdata", rdata0, 32'hDEADBEEF);
        check("raw_rd_ready", 32'(ro0), 32'd1);
        check("raw_rd_resp", 32'(resp0), 32'd0);

        // byte and halfword lanes
        cyc(TN, 32'h20, 1'b1, SW, 32'h0);
        cyc(TN, 32'h21, 1'b1, SB, 32'h00000000);
        cyc(TN, 32'h22, 1'b1, SH, 32'h0000AB00);
        cyc(TN, 32'h24, 1'b1, SW, 32'h12340000);
        cyc(TN, 32'h24, 1'b1, SB, 32'hFFFFFFFF);
        cyc(TN, 32'h20, 1'b0, SW, 32'hAAAAAA11);
        cyc(TN, 32'h24, 1'b0, SW, 32'h0);
        check("lanes_20", rdata0, 32'h1234AB00);
        cyc(TI, 32'h0, 1'b0, SB, 32'h0);
        check("lanes_24", rdata0, 32'hFFFFFF11);

        // back-to-back writes and reads
        cyc(TN, 32'h0, 1'b1, SW, 32'h0);
        cyc(TN, 32'h4, 1'b1, SW, 32'h11111111);
        check("b2b_ready_w0", 32'(ro0), 32'd1);
        cyc(TN, 32'h8, 1'b1, SW, 32'h22222222);
        check("b2b_ready_w1", 32'(ro0), 32'd1);
        cyc(TN, 32'h0, 1'b0, SW, 32'h33333333);
        check("b2b_ready_w2", 32'(ro0), 32'd1);
        cyc(TN, 32'h4, 1'b0, SW, 32'h0);
        check("b2b_rd0", rdata0, 32'h11111111);
        cyc(TN, 32'h8, 1'b0, SW, 32'h0);
        check("b2b_rd4", rdata0, 32'h22222222);
        cyc(TI, 32'h0, 1'b0, SB, 32'h0);
        check("b2b_rd8", rdata0, 32'h33333333);

        // misaligned halfword and out-of-range word, new read sampled in ERR2
        cyc(TN, 32'h3, 1'b1, SH, 32'h0);
        cyc(TI, 32'h0, 1'b0, SB, 32'hFFFFFFFF);
        check("mis_err1_ready", 32'(ro0), 32'd0);
        check("mis_err1_resp", 32'(resp0), 32'd1);
        cyc(TI, 32'h0, 1'b0, SB, 32'hFFFFFFFF);
        check("mis_err2_ready", 32'(ro0), 32'd1);
        check("mis_err2_resp", 32'(resp0), 32'd1);
        cyc(TN, 32'd4096, 1'b1, SW, 32'h0);
        check("mis_after_resp", 32'(resp0), 32'd0);
        cyc(TI, 32'h0, 1'b0, SB, 32'hEEEEEEEE);
        check("oor_err1_ready", 32'(ro0), 32'd0);
        check("oor_err1_resp", 32'(resp0), 32'd1);
        cyc(TN, 32'h0, 1'b0, SW, 32'hEEEEEEEE);
        check("oor_err2_ready", 32'(ro0), 32'd1);
        check("oor_err2_resp", 32'(resp0), 32'd1);
        cyc(TN, 32'h0, 1'b1, 3'd3, 32'h0);
        check("err_mem_word0", rdata0, 32'h11111111);
        check("err_rd_resp", 32'(resp0), 32'd0);
        cyc(TI, 32'h0, 1'b0, SB, 32'h0);
        check("size3_err1_resp", 32'(resp0), 32'd1);
        check("size3_err1_ready", 32'(ro0), 32'd0);
        cyc(TI, 32'h0, 1'b0, SB, 32'h0);
        cyc(TI, 32'h0, 1'b0, SB, 32'h0);
        check("err_idle_resp", 32'(resp0), 32'd0);

        // three wait states on dut3
        use3 = 1'b1;
        wr3(32'h4, 32'hCAFEF00D);
        cyc(TN, 32'h4, 1'b0, SW, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(TI, 32'h0, 1'b0, SB, 32'h0);
            check($sformatf("ws_wait%0d_ready", i), 32'(ro3), 32'd0);
            check($sformatf("ws_wait%0d_resp", i), 32'(resp3), 32'd0);
        end
        cyc(TI, 32'h0, 1'b0, SB, 32'h0);
        check("ws_data_ready", 32'(ro3), 32'd1);
        check("ws_rdata", rdata3, 32'hCAFEF00D);
        cyc(TI, 32'h0, 1'b0, SB, 32'h0);
        check("ws_idle_ready", 32'(ro3), 32'd1);

        // reset during the wait of a write must not commit it
        wr3(32'h30, 32'h5A5A5A5A);
        cyc(TN, 32'h30, 1'b1, SW, 32'h0);
        cyc(TI, 32'h0, 1'b0, SB, 32'hFFFFFFFF);
        check("abort_pre_ready", 32'(ro3), 32'd0);
        #2 hresetn = 1'b0;
        #1;
        check("abort_ready", 32'(ro3), 32'd1);
        check("abort_resp", 32'(resp3), 32'd0);
        check("abort_rdata", rdata3, 32'h0);
        @(posedge hclk);
        #1 hresetn = 1'b1;
        cyc(TN, 32'h30, 1'b0, SW, 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) cyc(TI, 32'h0, 1'b0, SB, 32'hFFFFFFFF);
        cyc(TI, 32'h0, 1'b0, SB, 32'hFFFFFFFF);
        check("abort_mem", rdata3, 32'h5A5A5A5A);
        check("abort_mem_ready", 32'(ro3), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
